// File: rtl/tt_dco.sv
// tt_dco: digitally controlled oscillator turning a loop-filter control word into a saturated FCW,
// a wrapping phase accumulator (scannable), a per-wrap tick and a divided feedback clock.
module tt_dco #(
  parameter int ACC_W = 24,
  parameter logic [ACC_W-1:0] CENTER_FCW = 24'h100000,
  parameter int GAIN_SHIFT = 6,
  parameter logic [ACC_W-1:0] FCW_MIN = 24'h040000,
  parameter logic [ACC_W-1:0] FCW_MAX = 24'h200000,
  parameter int DIV_N = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [15:0]      i_ctrl,
  output logic [ACC_W-1:0] o_fcw,
  output logic             o_sat,
  output logic             o_dco_clk,
  output logic             o_tick,
  output logic             o_fb_clk,
  input  logic             i_scan_en,
  input  logic             i_scan_in,
  output logic             o_scan_out
);
  localparam int SW = ACC_W + 2;
  localparam int DW = $clog2(DIV_N);
  localparam logic signed [SW-1:0] MAX_S = $signed({2'b00, FCW_MAX});
  localparam logic signed [SW-1:0] MIN_S = $signed({2'b00, FCW_MIN});
  logic [15:0]          ctrl_q;
  logic signed [SW-1:0] sum;
  logic                 over;
  logic                 under;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W:0]       acc_sum;
  logic [DW-1:0]        div_cnt;
  logic                 fb_toggle;
  // Two spare bits keep the widest positive sum and any negative sum representable.
  always_comb begin
    sum = $signed({2'b00, CENTER_FCW}) + ($signed({{(SW-16){ctrl_q[15]}}, ctrl_q}) <<< GAIN_SHIFT);
    over = sum > MAX_S;
    under = sum < MIN_S;
    acc_sum = {1'b0, acc} + {1'b0, o_fcw};
    fb_toggle = div_cnt == DW'(DIV_N/2-1) || div_cnt == DW'(DIV_N-1);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q <= '0;
      o_fcw <= CENTER_FCW;
      o_sat <= 1'b0;
    end else begin
      ctrl_q <= i_ctrl;
      o_fcw <= over ? FCW_MAX : under ? FCW_MIN : sum[ACC_W-1:0];
      o_sat <= over || under;
    end
  end
  // Scan takes precedence over running; the divider only advances on a run-mode carry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc <= '0;
      o_tick <= 1'b0;
      div_cnt <= '0;
      o_fb_clk <= 1'b0;
    end else if (i_scan_en) begin
      acc <= {acc[ACC_W-2:0], i_scan_in};
      o_tick <= 1'b0;
    end else if (i_enable) begin
      acc <= acc_sum[ACC_W-1:0];
      o_tick <= acc_sum[ACC_W];
      if (acc_sum[ACC_W]) begin
        div_cnt <= div_cnt == DW'(DIV_N-1) ? '0 : div_cnt + 1'b1;
        o_fb_clk <= fb_toggle ? ~o_fb_clk : o_fb_clk;
      end
    end else begin
      o_tick <= 1'b0;
    end
  end
  assign o_dco_clk = acc[ACC_W-1];
  assign o_scan_out = acc[ACC_W-1];
endmodule

// File: tb/tb_tt_dco.sv
// tb_tt_dco: directed checks of the DCO control pipeline, saturation, accumulator wrap,
// feedback divider, enable hold, scan load/unload and mid-run reset.
module tb_tt_dco;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [15:0] i_ctrl = '0;
  logic [23:0] o_fcw;
  logic        o_sat;
  logic        o_dco_clk;
  logic        o_tick;
  logic        o_fb_clk;
  logic        i_scan_en = 1'b0;
  logic        i_scan_in = 1'b0;
  logic        o_scan_out;
  int n_vec = 0;
  int n_err = 0;
  tt_dco dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_ctrl(i_ctrl),
    .o_fcw(o_fcw), .o_sat(o_sat), .o_dco_clk(o_dco_clk), .o_tick(o_tick),
    .o_fb_clk(o_fb_clk), .i_scan_en(i_scan_en), .i_scan_in(i_scan_in),
    .o_scan_out(o_scan_out)
  );
  always #5 i_clk = ~i_clk;
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic test_reset();
    i_rst = 1'b1;
    step();
    n_vec++;
    if ({o_fcw, o_sat, o_tick, o_fb_clk, o_dco_clk, o_scan_out} !== {24'h100000, 5'b0}) begin
      n_err++;
      $display("FAIL reset: fcw=%h sat=%b tick=%b fb=%b dco=%b so=%b, want fcw=100000 rest 0",
               o_fcw, o_sat, o_tick, o_fb_clk, o_dco_clk, o_scan_out);
    end
  endtask
  // Center FCW = 2^20: a wrap every 16 edges, fb toggles every 64 edges.
  task automatic test_free_run();
    logic e_tick, e_fb, e_dco;
    i_rst = 1'b0;
    i_enable = 1'b1;
    i_ctrl = 16'h0000;
    for (int n = 1; n <= 128; n++) begin
      step();
      e_tick = (n % 16) == 0;
      e_fb = ((n / 64) % 2) == 1;
      e_dco = (n % 16) >= 8;
      n_vec++;
      if (o_tick !== e_tick || o_fb_clk !== e_fb || o_dco_clk !== e_dco || o_fcw !== 24'h100000) begin
        n_err++;
        $display("FAIL free_run edge %0d: tick=%b fb=%b dco=%b fcw=%h, want tick=%b fb=%b dco=%b fcw=100000",
                 n, o_tick, o_fb_clk, o_dco_clk, o_fcw, e_tick, e_fb, e_dco);
      end
    end
  endtask
  // acc=0 at entry; new FCW lands on edge 2 and first accumulates on edge 3, so the next wrap is edge 14.
  task automatic test_ctrl_gain();
    logic e_tick;
    i_ctrl = 16'h1000;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (n == 1 || n == 2) begin
        n_vec++;
        if (o_fcw !== (n == 1 ? 24'h100000 : 24'h140000) || o_sat !== 1'b0) begin
          n_err++;
          $display("FAIL ctrl_gain latency edge %0d: fcw=%h sat=%b", n, o_fcw, o_sat);
        end
      end
      e_tick = n == 14;
      n_vec++;
      if (o_tick !== e_tick || o_fb_clk !== 1'b0) begin
        n_err++;
        $display("FAIL ctrl_gain wrap edge %0d: tick=%b fb=%b, want tick=%b fb=0", n, o_tick, o_fb_clk, e_tick);
      end
    end
  endtask
  task automatic test_saturation();
    logic [15:0] c_tab [8] = '{16'h7FFF, 16'h8000, 16'h4000, 16'h4001, 16'hD000, 16'hCFFF, 16'h0400, 16'hFC00};
    logic [23:0] f_tab [8] = '{24'h200000, 24'h040000, 24'h200000, 24'h200000,
                               24'h040000, 24'h040000, 24'h110000, 24'h0F0000};
    logic        s_tab [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    i_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_ctrl = c_tab[i];
      step();
      step();
      n_vec++;
      if (o_fcw !== f_tab[i] || o_sat !== s_tab[i]) begin
        n_err++;
        $display("FAIL saturation ctrl=%h: fcw=%h sat=%b, want fcw=%h sat=%b",
                 c_tab[i], o_fcw, o_sat, f_tab[i], s_tab[i]);
      end
    end
  endtask
  // 40 enabled edges, 10 idle, then 30 more: the sequence must match 70 uninterrupted edges.
  task automatic test_enable_hold();
    logic e_tick, e_fb, e_dco;
    i_ctrl = 16'h0000;
    test_reset();
    i_rst = 1'b0;
    i_enable = 1'b1;
    for (int m = 1; m <= 40; m++) step();
    i_enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_vec++;
      if (o_tick !== 1'b0 || o_dco_clk !== 1'b1 || o_fb_clk !== 1'b0) begin
        n_err++;
        $display("FAIL enable_hold idle %0d: tick=%b dco=%b fb=%b, want 0 1 0", k, o_tick, o_dco_clk, o_fb_clk);
      end
    end
    i_enable = 1'b1;
    for (int m = 41; m <= 70; m++) begin
      step();
      e_tick = (m % 16) == 0;
      e_fb = m >= 64;
      e_dco = (m % 16) >= 8;
      n_vec++;
      if (o_tick !== e_tick || o_fb_clk !== e_fb || o_dco_clk !== e_dco) begin
        n_err++;
        $display("FAIL enable_hold resume %0d: tick=%b fb=%b dco=%b, want %b %b %b",
                 m, o_tick, o_fb_clk, o_dco_clk, e_tick, e_fb, e_dco);
      end
    end
  endtask
  // Entry state: acc=0x600000, div_cnt=4, fb=1.
  task automatic test_scan();
    logic [23:0] pat = 24'hFFFFF0;
    logic [23:0] prior = 24'h600000;
    logic [23:0] post = 24'h0FFFF0;
    i_scan_en = 1'b1;
    for (int j = 0; j < 24; j++) begin
      i_scan_in = pat[23-j];
      n_vec++;
      if (o_scan_out !== prior[23-j]) begin
        n_err++;
        $display("FAIL scan_unload bit %0d: so=%b want %b", 23 - j, o_scan_out, prior[23-j]);
      end
      step();
      n_vec++;
      if (o_tick !== 1'b0 || o_fb_clk !== 1'b1) begin
        n_err++;
        $display("FAIL scan_hold shift %0d: tick=%b fb=%b, want 0 1", j, o_tick, o_fb_clk);
      end
    end
    i_scan_en = 1'b0;
    step();
    n_vec++;
    if (o_tick !== 1'b1 || o_dco_clk !== 1'b0 || o_fb_clk !== 1'b1) begin
      n_err++;
      $display("FAIL scan_resume: tick=%b dco=%b fb=%b, want 1 0 1", o_tick, o_dco_clk, o_fb_clk);
    end
    i_scan_en = 1'b1;
    i_scan_in = 1'b0;
    for (int j = 0; j < 24; j++) begin
      n_vec++;
      if (o_scan_out !== post[23-j]) begin
        n_err++;
        $display("FAIL scan_readback bit %0d: so=%b want %b", 23 - j, o_scan_out, post[23-j]);
      end
      step();
    end
    i_scan_en = 1'b0;
  endtask
  task automatic test_reset_mid_run();
    i_ctrl = 16'h0000;
    test_reset();
    i_rst = 1'b0;
    i_enable = 1'b1;
    for (int n = 0; n < 64; n++) step();
    i_ctrl = 16'h1000;
    for (int n = 0; n < 3; n++) step();
    n_vec++;
    if (o_fcw !== 24'h140000 || o_fb_clk !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_run pre: fcw=%h fb=%b, want 140000 1", o_fcw, o_fb_clk);
    end
    test_reset();
    i_rst = 1'b0;
    step();
    n_vec++;
    if (o_fcw !== 24'h100000 || o_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_run refill1: fcw=%h sat=%b, want 100000 0", o_fcw, o_sat);
    end
    step();
    n_vec++;
    if (o_fcw !== 24'h140000 || o_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_run refill2: fcw=%h sat=%b, want 140000 0", o_fcw, o_sat);
    end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_ctrl_gain();
    test_saturation();
    test_enable_hold();
    test_scan();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
